// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage sequencer for the shared single-port data RAM. Arbitrates between
// pipeline loads/stores and a debug port, waits on the RAM ready handshake
// while holding Stall, and returns final (lane-extracted, optionally
// sign-extended) load data for the MEM/WB register.
//
// Optional feature macro: MEM_CTRL_TIMEOUT_EN
//   defined   -> accesses abort after TIMEOUT_CYCLES wait cycles, mem_err sticky
//   undefined -> waits indefinitely, mem_err tied low, no TIMEOUT_CYCLES param
//
// Ports:
//   clk, reset (sync, active-low)
//   mem_rd_in / mem_wr_in / mem_sel_in / mem_sign_ext_flag_in : CPU request
//   addr_in / wdata_in                                        : CPU address/data
//   dbg_req / dbg_we / dbg_addr / dbg_wdata                   : debug request
//   dbg_done / dbg_rdata                                      : debug completion
//   ram_en / ram_we / ram_addr / ram_wdata                    : RAM request
//   ram_rdata / ram_ready                                     : RAM response
//   Stall                                                     : pipeline freeze
//   ram_read_data_out                                         : load data to WB
//   mem_err                                                   : sticky timeout
// -----------------------------------------------------------------------------
module mem_access_ctrl
`ifdef MEM_CTRL_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 15)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic [3:0]  mem_sel_in,
  input  logic        mem_sign_ext_flag_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        Stall,
  output logic [31:0] ram_read_data_out,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    DBG_ACC  = 2'd2,
    CPU_DONE = 2'd3
  } state_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  state_t      state_q;
  logic        rr_flag_q;
  // CPU request attributes captured at grant so completion does not depend
  // on the pipeline holding its inputs stable.
  logic        cpu_wr_q;
  logic        sext_q;
  logic [3:0]  sel_q;

  logic        ram_en_q;
  logic [3:0]  ram_we_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic        dbg_done_q;
  logic [31:0] dbg_rdata_q;
  logic [31:0] rd_data_q;

  logic        cpu_req;
  logic        cpu_grant;
  logic        tmo_hit;
  logic [31:0] load_d;
  logic [31:0] lane_ext [4];

  assign cpu_req   = mem_rd_in | mem_wr_in;
  // Under contention rr_flag_q=1 means the CPU won last time, so debug goes now.
  assign cpu_grant = cpu_req & (~dbg_req | ~rr_flag_q);
  assign Stall     = cpu_req & (state_q != CPU_DONE);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_ext[gi] = {{24{sext_q & ram_rdata[8*gi+7]}}, ram_rdata[8*gi +: 8]};
    end
  endgenerate

  always_comb begin
    load_d = ram_rdata;
    case (sel_q)
      4'b0001: load_d = lane_ext[0];
      4'b0010: load_d = lane_ext[1];
      4'b0100: load_d = lane_ext[2];
      4'b1000: load_d = lane_ext[3];
      4'b0011: load_d = {{16{sext_q & ram_rdata[15]}}, ram_rdata[15:0]};
      4'b1100: load_d = {{16{sext_q & ram_rdata[31]}}, ram_rdata[31:16]};
      default: load_d = ram_rdata;
    endcase
  end

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             mem_err_q;

  // Abort on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign tmo_hit = ram_en_q & ~ram_ready & (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      mem_err_q <= 1'b0;
    end else if (!ram_en_q) begin
      tmo_cnt_q <= '0;
    end else if (!ram_ready) begin
      if (tmo_hit) begin
        tmo_cnt_q <= '0;
        mem_err_q <= 1'b1;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem_err = mem_err_q;
`else
  assign tmo_hit = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_flag_q   <= 1'b0;
      cpu_wr_q    <= 1'b0;
      sext_q      <= 1'b0;
      sel_q       <= 4'h0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'h0;
      ram_addr_q  <= 32'h0;
      ram_wdata_q <= 32'h0;
      dbg_done_q  <= 1'b0;
      dbg_rdata_q <= 32'h0;
      rd_data_q   <= 32'h0;
    end else begin
      dbg_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_grant) begin
            if (dbg_req) rr_flag_q <= 1'b1;
            state_q     <= CPU_ACC;
            cpu_wr_q    <= mem_wr_in;
            sel_q       <= mem_sel_in;
            sext_q      <= mem_sign_ext_flag_in;
            ram_en_q    <= 1'b1;
            ram_we_q    <= mem_wr_in ? mem_sel_in : 4'h0;
            ram_addr_q  <= {addr_in[31:2], 2'b00};
            ram_wdata_q <= wdata_in;
          end else if (dbg_req) begin
            if (cpu_req) rr_flag_q <= 1'b0;
            state_q     <= DBG_ACC;
            ram_en_q    <= 1'b1;
            ram_we_q    <= dbg_we ? 4'hF : 4'h0;
            ram_addr_q  <= {dbg_addr[31:2], 2'b00};
            ram_wdata_q <= dbg_wdata;
          end
        end
        CPU_ACC: begin
          if (ram_ready || tmo_hit) begin
            state_q  <= CPU_DONE;
            ram_en_q <= 1'b0;
            ram_we_q <= 4'h0;
            if (!cpu_wr_q) rd_data_q <= tmo_hit ? ABORT_DATA : load_d;
          end
        end
        DBG_ACC: begin
          if (ram_ready || tmo_hit) begin
            state_q    <= IDLE;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 4'h0;
            dbg_done_q <= 1'b1;
            // Debug writes always drive all four lanes, so we==0 means read.
            if (tmo_hit)               dbg_rdata_q <= ABORT_DATA;
            else if (ram_we_q == 4'h0) dbg_rdata_q <= ram_rdata;
          end
        end
        CPU_DONE: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign ram_en            = ram_en_q;
  assign ram_we            = ram_we_q;
  assign ram_addr          = ram_addr_q;
  assign ram_wdata         = ram_wdata_q;
  assign dbg_done          = dbg_done_q;
  assign dbg_rdata         = dbg_rdata_q;
  assign ram_read_data_out = rd_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench: directed reset/contention/reset-mid-access cases plus
// randomized CPU and debug transactions checked against a transaction-level
// reference model (expected data, latency, lane values).
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd_in, mem_wr_in, mem_sign_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] addr_in, wdata_in;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_done;
  logic [31:0] dbg_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ready;
  logic        Stall;
  logic [31:0] ram_read_data_out;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_load   = 32'h0;
  logic [31:0] m_dbg    = 32'h0;
  logic        m_err    = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset),
    .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in), .mem_sel_in(mem_sel_in),
    .mem_sign_ext_flag_in(mem_sign_ext_flag_in),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .Stall(Stall), .ram_read_data_out(ram_read_data_out), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Load result from the lane rules: pick the selected byte/half by shifting,
  // then extend from its top bit.
  function automatic logic [31:0] model_load(input logic [3:0] sel, input logic sx,
                                             input logic [31:0] d);
    int lane, width;
    logic [31:0] mask, v;
    lane = 0; width = 32;
    case (sel)
      4'b0001: begin lane = 0; width = 8;  end
      4'b0010: begin lane = 1; width = 8;  end
      4'b0100: begin lane = 2; width = 8;  end
      4'b1000: begin lane = 3; width = 8;  end
      4'b0011: begin lane = 0; width = 16; end
      4'b1100: begin lane = 2; width = 16; end
      default: begin lane = 0; width = 32; end
    endcase
    if (width == 32) return d;
    mask = (32'h1 << width) - 32'h1;
    v = (d >> (8 * lane)) & mask;
    if (sx && v[width-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    mem_rd_in = 0; mem_wr_in = 0; mem_sel_in = 0; mem_sign_ext_flag_in = 0;
    addr_in = 0; wdata_in = 0; dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    ram_rdata = 0; ram_ready = 0;
  endtask

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic cpu_access(input logic rd, input logic wr, input logic [3:0] sel,
                            input logic sx, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdat,
                            input int waits);
    int stall_n, en_n, exp_stall;
    bit done;
    logic [31:0] exp_data;
    mem_rd_in = rd; mem_wr_in = wr; mem_sel_in = sel; mem_sign_ext_flag_in = sx;
    addr_in = addr; wdata_in = wd; ram_rdata = rdat; ram_ready = 0;
    stall_n = 0; en_n = 0; done = 0;
    exp_stall = waits + 2;
    exp_data  = wr ? m_load : model_load(sel, sx, rdat);
`ifdef MEM_CTRL_TIMEOUT_EN
    if (waits >= TMO) begin
      exp_stall = TMO + 1;
      if (!wr) exp_data = 32'hDEADBEEF;
      m_err = 1'b1;
    end
`endif
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (Stall) stall_n++;
      else begin
        done = 1;
        chk("cpu_data", ram_read_data_out, exp_data);
        chk("cpu_stall_cycles", stall_n, exp_stall);
        chk("cpu_en_off", {31'h0, ram_en}, 32'h0);
        chk("cpu_mem_err", {31'h0, mem_err}, {31'h0, m_err});
      end
      if (ram_en) begin
        chk("cpu_addr", ram_addr, {addr[31:2], 2'b00});
        chk("cpu_we", {28'h0, ram_we}, {28'h0, (wr ? sel : 4'h0)});
        chk("cpu_wdata", ram_wdata, wd);
        ram_ready = (en_n == waits);
        en_n++;
      end else ram_ready = 0;
      if (!done) begin @(posedge clk); #1; end
    end
    if (!done) chk("cpu_cycle_budget", 32'h0, 32'h1);
    m_load = exp_data;
    $display("cpu %s addr=%08h sel=%h sx=%0d waits=%0d data=%08h stall=%0d",
             wr ? "st" : "ld", addr, sel, sx, waits, ram_read_data_out, stall_n);
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic dbg_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdat,
                            input int waits);
    int en_n;
    bit done;
    dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    ram_rdata = rdat; ram_ready = 0;
    en_n = 0; done = 0;
    if (!we) m_dbg = rdat;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (dbg_done) begin
        done = 1;
        chk("dbg_rdata", dbg_rdata, m_dbg);
        chk("dbg_stall", {31'h0, Stall}, 32'h0);
      end
      if (ram_en) begin
        chk("dbg_addr", ram_addr, {addr[31:2], 2'b00});
        chk("dbg_we", {28'h0, ram_we}, we ? 32'hF : 32'h0);
        ram_ready = (en_n == waits);
        en_n++;
      end else ram_ready = 0;
      if (!done) begin @(posedge clk); #1; end
    end
    if (!done) chk("dbg_cycle_budget", 32'h0, 32'h1);
    $display("dbg %s addr=%08h waits=%0d rdata=%08h", we ? "wr" : "rd", addr, waits, dbg_rdata);
    idle_inputs();
    @(posedge clk); #1;
    chk("dbg_done_pulse", {31'h0, dbg_done}, 32'h0);
  endtask

  initial begin
    logic [3:0] sel_tab [8];
    sel_tab[0] = 4'hF; sel_tab[1] = 4'h3; sel_tab[2] = 4'hC; sel_tab[3] = 4'h1;
    sel_tab[4] = 4'h2; sel_tab[5] = 4'h4; sel_tab[6] = 4'h8; sel_tab[7] = 4'h6;

    idle_inputs();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", {31'h0, ram_en}, 32'h0);
    chk("rst_rdata_out", ram_read_data_out, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    chk("rst_stall", {31'h0, Stall}, 32'h0);
    reset = 1;
    @(posedge clk); #1;

    // directed plan cases
    cpu_access(1, 0, 4'hF, 0, 32'h104, 32'h0, 32'h11223344, 0);
    cpu_access(1, 0, 4'h4, 1, 32'h200, 32'h0, 32'h0080FF00, 3);
    chk("sbyte_ext", ram_read_data_out, 32'hFFFFFF80);
    cpu_access(1, 0, 4'h4, 0, 32'h200, 32'h0, 32'h0080FF00, 3);
    chk("sbyte_zext", ram_read_data_out, 32'h00000080);
    cpu_access(0, 1, 4'hC, 0, 32'h302, 32'hABCD0000, 32'h55555555, 2);
    chk("store_keeps", ram_read_data_out, 32'h00000080);

    // contention: CPU wins first, debug wins the next contended grant
    mem_rd_in = 1; mem_sel_in = 4'hF; addr_in = 32'h400; ram_rdata = 32'hCAFE0001;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h800;
    @(posedge clk); #1;
    chk("cont1_cpu_addr", ram_addr, 32'h400);
    ram_ready = 1;
    @(posedge clk); #1;
    chk("cont1_stall_rel", {31'h0, Stall}, 32'h0);
    chk("cont1_data", ram_read_data_out, 32'hCAFE0001);
    addr_in = 32'h500; ram_ready = 0; ram_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("cont2_dbg_addr", ram_addr, 32'h800);
    chk("cont2_stall", {31'h0, Stall}, 32'h1);
    ram_ready = 1;
    @(posedge clk); #1;
    chk("cont2_done", {31'h0, dbg_done}, 32'h1);
    chk("cont2_rdata", dbg_rdata, 32'h0BADF00D);
    chk("cont2_stall_held", {31'h0, Stall}, 32'h1);
    m_dbg = 32'h0BADF00D;
    dbg_req = 0; ram_ready = 0; ram_rdata = 32'h12345678;
    @(posedge clk); #1;
    chk("cont3_done_low", {31'h0, dbg_done}, 32'h0);
    chk("cont3_cpu_addr", ram_addr, 32'h500);
    ram_ready = 1;
    @(posedge clk); #1;
    chk("cont3_data", ram_read_data_out, 32'h12345678);
    m_load = 32'h12345678;
    $display("contention sequence done");
    idle_inputs();
    @(posedge clk); #1;

    // reset in the middle of a stalled store
    mem_wr_in = 1; mem_sel_in = 4'hC; addr_in = 32'h600; wdata_in = 32'hABCD0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_en", {31'h0, ram_en}, 32'h1);
    reset = 0;
    @(posedge clk); #1;
    chk("mid_rst_en", {31'h0, ram_en}, 32'h0);
    chk("mid_rst_we", {28'h0, ram_we}, 32'h0);
    chk("mid_rst_addr", ram_addr, 32'h0);
    chk("mid_rst_wdata", ram_wdata, 32'h0);
    chk("mid_rst_rdout", ram_read_data_out, 32'h0);
    chk("mid_rst_dbg", dbg_rdata, 32'h0);
    m_load = 32'h0; m_dbg = 32'h0; m_err = 1'b0;
    reset = 1;
    $display("reset mid-access applied");
    cpu_access(0, 1, 4'hC, 0, 32'h600, 32'hABCD0000, 32'h0, 1);

`ifdef MEM_CTRL_TIMEOUT_EN
    cpu_access(1, 0, 4'hF, 0, 32'h700, 32'h0, 32'h11111111, 1000);
`endif

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 2) begin
        dbg_access(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom_range(0, 4));
      end else begin
        logic wr, rd;
        logic [3:0] sel;
        wr = (kind == 1);
        rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        sel = ($urandom_range(0, 7) == 7) ? 4'($urandom_range(0, 15)) : sel_tab[$urandom_range(0, 7)];
        cpu_access(rd, wr, sel, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 4));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
